// File: rtl/hd_bitop_pipe_if.sv
// rtl/hd_bitop_pipe_if.sv - request/result handshake bundle for hd_bitop_pipe
interface hd_bitop_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_flag;
    logic [2:0]       out_op;

    modport master (
        output in_valid, in_op, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_flag, out_op
    );

    modport slave (
        input  in_valid, in_op, in_data, out_ready,
        output in_ready, out_valid, out_data, out_flag, out_op
    );
endinterface

// File: rtl/hd_bitop_pipe.sv
// rtl/hd_bitop_pipe.sv - two-stage WIDTH-generic bit-manipulation pipeline
module hd_bitop_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    hd_bitop_pipe_if.slave   bus,
    output logic [CNT_W-1:0] done_cnt
);
    localparam int SH = $clog2(WIDTH);
    localparam int CW = SH + 1;

    typedef enum logic [2:0] {
        OP_ABS    = 3'd0,
        OP_POPCNT = 3'd1,
        OP_CLZ    = 3'd2,
        OP_CTZ    = 3'd3,
        OP_LOW1   = 3'd4,
        OP_CLR1   = 3'd5,
        OP_CLP2   = 3'd6,
        OP_PASS   = 3'd7
    } op_e;

    function automatic logic [CW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++) begin
            c = c + CW'(v[i]);
        end
        return c;
    endfunction

    // Index of the lowest set bit, WIDTH when none; fed the reversed operand it yields clz.
    function automatic logic [CW-1:0] first_one(input logic [WIDTH-1:0] v);
        logic [CW-1:0] c;
        c = CW'(WIDTH);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                c = CW'(i);
            end
        end
        return c;
    endfunction

    function automatic logic [WIDTH-1:0] smear_right(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] s;
        s = v;
        for (int i = 0; i < SH; i++) begin
            s = s | (s >> (1 << i));
        end
        return s;
    endfunction

    function automatic logic [WIDTH-1:0] zext(input logic [CW-1:0] c);
        return {{(WIDTH - CW){1'b0}}, c};
    endfunction

    logic             s1_valid;
    logic             s2_valid;
    op_e              s1_op;
    logic [WIDTH-1:0] s1_x;
    logic [WIDTH-1:0] s1_neg;
    logic [WIDTH-1:0] s1_dec;
    logic [WIDTH-1:0] s1_rev;

    logic [WIDTH-1:0] rev_x;
    logic [WIDTH-1:0] res;
    logic             flg;

    logic [WIDTH-1:0] out_data_q;
    logic             out_flag_q;
    logic [2:0]       out_op_q;

    logic in_fire;
    logic s2_take;
    logic out_fire;

    // Ready depends only on state and out_ready so upstream may wait on it combinationally.
    assign bus.in_ready  = ~s1_valid | ~s2_valid | bus.out_ready;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = out_data_q;
    assign bus.out_flag  = out_flag_q;
    assign bus.out_op    = out_op_q;

    assign in_fire  = bus.in_valid & bus.in_ready;
    assign out_fire = s2_valid & bus.out_ready;
    assign s2_take  = s1_valid & (~s2_valid | bus.out_ready);

    always_comb begin
        rev_x = '0;
        for (int i = 0; i < WIDTH; i++) begin
            rev_x[i] = bus.in_data[WIDTH-1-i];
        end
    end

    always_comb begin
        res = '0;
        flg = 1'b0;
        case (s1_op)
            OP_ABS: begin
                res = s1_x[WIDTH-1] ? s1_neg : s1_x;
                flg = s1_x[WIDTH-1] & ~|s1_x[WIDTH-2:0];
            end
            OP_POPCNT: begin
                res = zext(popcount(s1_x));
                flg = ~|s1_x;
            end
            OP_CLZ: begin
                res = zext(first_one(s1_rev));
                flg = ~|s1_x;
            end
            OP_CTZ: begin
                // ~x & (x-1) is a mask of exactly the trailing zeros.
                res = zext(popcount(~s1_x & s1_dec));
                flg = ~|s1_x;
            end
            OP_LOW1: begin
                res = s1_x & s1_neg;
                flg = ~|s1_x;
            end
            OP_CLR1: begin
                res = s1_x & s1_dec;
                flg = ~|res;
            end
            OP_CLP2: begin
                // x=0 and x>2^(W-1) both wrap to 0; only the latter is an overflow.
                res = smear_right(s1_dec) + WIDTH'(1);
                flg = (|s1_x) & ~|res;
            end
            OP_PASS: begin
                res = s1_x;
                flg = 1'b1;
            end
            default: begin
                res = s1_x;
                flg = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            done_cnt <= '0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
                s2_valid <= 1'b0;
            end else begin
                if (in_fire) begin
                    s1_valid <= 1'b1;
                end else if (s2_take) begin
                    s1_valid <= 1'b0;
                end
                if (s2_take) begin
                    s2_valid <= 1'b1;
                end else if (out_fire) begin
                    s2_valid <= 1'b0;
                end
            end
            if (out_fire) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_op  <= OP_ABS;
            s1_x   <= '0;
            s1_neg <= '0;
            s1_dec <= '0;
            s1_rev <= '0;
        end else if (in_fire && !flush) begin
            s1_op  <= op_e'(bus.in_op);
            s1_x   <= bus.in_data;
            s1_neg <= '0 - bus.in_data;
            s1_dec <= bus.in_data - WIDTH'(1);
            s1_rev <= rev_x;
        end
    end

    // The output register only moves when empty or draining, so it holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q <= '0;
            out_flag_q <= 1'b0;
            out_op_q   <= 3'd0;
        end else if (s2_take && !flush) begin
            out_data_q <= res;
            out_flag_q <= flg;
            out_op_q   <= s1_op;
        end
    end
endmodule

// File: tb/tb_hd_bitop_pipe.sv
// tb/tb_hd_bitop_pipe.sv - self-checking bench for hd_bitop_pipe at WIDTH 32, 8 and 16
module tb_hd_bitop_pipe;
    typedef struct {
        logic [2:0]  op;
        logic [31:0] x;
        logic [31:0] r;
        logic        f;
    } vec_t;

    typedef struct {
        logic [2:0]  op;
        logic [32:0] fr;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        flush32 = 1'b0;
    logic        flush8 = 1'b0;
    logic        flush16 = 1'b0;
    logic [15:0] done32;
    logic [3:0]  done8;
    logic [15:0] done16;

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    bit   lat_check = 1'b0;
    bit   rand_rdy = 1'b0;
    exp_t exp_q[$];

    vec_t        tab32[16];
    vec_t        tab8[6];
    logic [2:0]  bp_op[4];
    logic [31:0] bp_x[4];
    logic [32:0] fr0;
    logic [15:0] base;

    hd_bitop_pipe_if #(.WIDTH(32)) if32 ();
    hd_bitop_pipe_if #(.WIDTH(8))  if8 ();
    hd_bitop_pipe_if #(.WIDTH(16)) if16 ();

    hd_bitop_pipe #(.WIDTH(32), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush32), .bus(if32), .done_cnt(done32));
    hd_bitop_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8), .bus(if8), .done_cnt(done8));
    hd_bitop_pipe #(.WIDTH(16), .CNT_W(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .flush(flush16), .bus(if16), .done_cnt(done16));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference results straight from the opcode definitions: {flag, result}.
    function automatic logic [32:0] model(input int w, input logic [2:0] op, input logic [31:0] xin);
        longint m, x, half, r, p;
        bit f;
        m = (longint'(1) << w) - 1;
        x = {32'd0, xin} & m;
        half = longint'(1) << (w - 1);
        r = 0;
        f = 1'b0;
        case (op)
            3'd0: begin r = (x >= half) ? ((m + 1 - x) & m) : x; f = (x == half); end
            3'd1: begin for (int i = 0; i < w; i++) r += (x >> i) & 1; f = (x == 0); end
            3'd2: begin r = w; for (int i = 0; i < w; i++) if (((x >> i) & 1) != 0) r = w - 1 - i; f = (x == 0); end
            3'd3: begin r = w; for (int i = w - 1; i >= 0; i--) if (((x >> i) & 1) != 0) r = i; f = (x == 0); end
            3'd4, 3'd5: begin
                p = 1;
                while (x != 0 && (x & p) == 0) p = p << 1;
                if (op == 3'd4) begin r = (x == 0) ? 0 : p; f = (x == 0); end
                else begin r = (x == 0) ? 0 : x - p; f = (r == 0); end
            end
            3'd6: begin
                if (x == 0) begin r = 0; f = 1'b0; end
                else begin
                    p = 1;
                    while (p < x) p = p << 1;
                    if (p > half) begin r = 0; f = 1'b1; end
                    else r = p;
                end
            end
            default: begin r = x; f = 1'b1; end
        endcase
        return {f, r[31:0]};
    endfunction

    function automatic logic [31:0] rand_x(input int w);
        longint v;
        int k;
        k = int'($urandom_range(0, w - 1));
        case ($urandom_range(0, 4))
            0: v = ($urandom_range(0, 1) != 0) ? 0 : (longint'(1) << (w - 1));
            1: v = longint'(1) << k;
            2: v = (longint'(1) << k) + 1;
            3: v = (longint'(1) << k) - 1;
            default: v = longint'($urandom);
        endcase
        v = v & ((longint'(1) << w) - 1);
        return v[31:0];
    endfunction

    task automatic monitor32();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_q.delete();
            end else begin
                if (if32.out_valid && if32.out_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL out32_extra: got op %0d data 0x%0h, expected no output", if32.out_op, if32.out_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("out32", 64'({if32.out_op, if32.out_flag, if32.out_data}), 64'({e.op, e.fr}));
                        if (lat_check) check("lat32", 64'(cyc - e.cyc), 64'd2);
                    end
                end
                if (flush32) exp_q.delete();
            end
        end
    endtask

    // Called just after a rising edge; returns just after the edge that takes the request.
    task automatic send32(input logic [2:0] op, input logic [31:0] x, input logic [32:0] fr);
        int   n;
        exp_t e;
        n = 0;
        if32.in_valid = 1'b1;
        if32.in_op    = op;
        if32.in_data  = x;
        @(negedge clk);
        while (!if32.in_ready && n < 64) begin
            @(posedge clk);
            #1;
            if (rand_rdy) if32.out_ready = ($urandom % 2) != 0;
            @(negedge clk);
            n++;
        end
        if (n >= 64) begin
            vectors++;
            miscompares++;
            $display("FAIL send32_timeout: in_ready got 0 expected 1");
        end else if (!flush32 && rst_n) begin
            e.op  = op;
            e.fr  = fr;
            e.cyc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        if32.in_valid = 1'b0;
        if (rand_rdy) if32.out_ready = ($urandom % 2) != 0;
    endtask

    task automatic drain32();
        int n;
        n = 0;
        if32.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 64) begin
            @(negedge clk);
            n++;
        end
        check("drain32", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic one8(input logic [2:0] op, input logic [7:0] x, input logic [8:0] fr);
        int n;
        @(posedge clk);
        #1;
        if8.out_ready = 1'b1;
        if8.in_valid  = 1'b1;
        if8.in_op     = op;
        if8.in_data   = x;
        @(negedge clk);
        check("in_ready8", 64'(if8.in_ready), 64'd1);
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!if8.out_valid && n < 8);
        check("out8", 64'({if8.out_op, if8.out_flag, if8.out_data}), 64'({op, fr}));
        check("lat8", 64'(n), 64'd2);
    endtask

    task automatic one16(input logic [2:0] op, input logic [15:0] x, input logic [16:0] fr);
        int n;
        @(posedge clk);
        #1;
        if16.out_ready = 1'b1;
        if16.in_valid  = 1'b1;
        if16.in_op     = op;
        if16.in_data   = x;
        @(posedge clk);
        #1;
        if16.in_valid = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!if16.out_valid && n < 8);
        check("out16", 64'({if16.out_op, if16.out_flag, if16.out_data}), 64'({op, fr}));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [32:0] m;
        logic [31:0] x;
        logic [2:0]  op;

        tab32[0]  = '{3'd0, 32'hFFFFFFFB, 32'h5,        1'b0};
        tab32[1]  = '{3'd0, 32'h80000000, 32'h80000000, 1'b1};
        tab32[2]  = '{3'd1, 32'hF0F0000F, 32'd12,       1'b0};
        tab32[3]  = '{3'd2, 32'h00010000, 32'd15,       1'b0};
        tab32[4]  = '{3'd3, 32'h0,        32'd32,       1'b1};
        tab32[5]  = '{3'd4, 32'h58,       32'h8,        1'b0};
        tab32[6]  = '{3'd5, 32'h40,       32'h0,        1'b1};
        tab32[7]  = '{3'd6, 32'h41,       32'h80,       1'b0};
        tab32[8]  = '{3'd6, 32'h80000001, 32'h0,        1'b1};
        tab32[9]  = '{3'd7, 32'h1234,     32'h1234,     1'b1};
        tab32[10] = '{3'd1, 32'h0,        32'd0,        1'b1};
        tab32[11] = '{3'd6, 32'h0,        32'h0,        1'b0};
        tab32[12] = '{3'd3, 32'h80000000, 32'd31,       1'b0};
        tab32[13] = '{3'd2, 32'h1,        32'd31,       1'b0};
        tab32[14] = '{3'd6, 32'h80000000, 32'h80000000, 1'b0};
        tab32[15] = '{3'd0, 32'h7,        32'h7,        1'b0};
        tab8[0]   = '{3'd2, 32'h0,  32'd8,  1'b1};
        tab8[1]   = '{3'd6, 32'h81, 32'h0,  1'b1};
        tab8[2]   = '{3'd0, 32'h80, 32'h80, 1'b1};
        tab8[3]   = '{3'd6, 32'h80, 32'h80, 1'b0};
        tab8[4]   = '{3'd1, 32'hFF, 32'd8,  1'b0};
        tab8[5]   = '{3'd5, 32'h6,  32'h4,  1'b0};

        if32.in_valid = 1'b0; if32.in_op = 3'd0; if32.in_data = '0; if32.out_ready = 1'b0;
        if8.in_valid  = 1'b0; if8.in_op  = 3'd0; if8.in_data  = '0; if8.out_ready  = 1'b0;
        if16.in_valid = 1'b0; if16.in_op = 3'd0; if16.in_data = '0; if16.out_ready = 1'b0;

        fork
            monitor32();
        join_none

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(if32.out_valid), 64'd0);
        check("rst_out_data",  64'(if32.out_data),  64'd0);
        check("rst_out_flag",  64'(if32.out_flag),  64'd0);
        check("rst_out_op",    64'(if32.out_op),    64'd0);
        check("rst_done_cnt",  64'(done32),         64'd0);
        check("rst_in_ready",  64'(if32.in_ready),  64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Known vectors streamed back to back with fixed two-edge latency.
        if32.out_ready = 1'b1;
        lat_check = 1'b1;
        foreach (tab32[i]) send32(tab32[i].op, tab32[i].x, {tab32[i].f, tab32[i].r});
        drain32();
        lat_check = 1'b0;
        check("done_table", 64'(done32), 64'd16);

        // Backpressure: two accepted, the rest wait, output held on the first result.
        base = done32;
        if32.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bp_op[i] = 3'($urandom_range(0, 7));
            bp_x[i]  = rand_x(32);
        end
        fr0 = model(32, bp_op[0], bp_x[0]);
        send32(bp_op[0], bp_x[0], fr0);
        send32(bp_op[1], bp_x[1], model(32, bp_op[1], bp_x[1]));
        if32.in_valid = 1'b1;
        if32.in_op    = bp_op[2];
        if32.in_data  = bp_x[2];
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("bp_in_ready", 64'(if32.in_ready), 64'd0);
            check("bp_out_valid", 64'(if32.out_valid), 64'd1);
            check("bp_hold", 64'({if32.out_op, if32.out_flag, if32.out_data}), 64'({bp_op[0], fr0}));
            @(posedge clk);
            #1;
        end
        if32.out_ready = 1'b1;
        send32(bp_op[2], bp_x[2], model(32, bp_op[2], bp_x[2]));
        send32(bp_op[3], bp_x[3], model(32, bp_op[3], bp_x[3]));
        drain32();
        check("bp_done", 64'(done32 - base), 64'd4);

        // Flush with a full, stalled pipe and a competing request.
        base = done32;
        if32.out_ready = 1'b0;
        send32(3'd7, 32'hA, model(32, 3'd7, 32'hA));
        send32(3'd7, 32'hB, model(32, 3'd7, 32'hB));
        if32.in_valid = 1'b1;
        if32.in_op    = 3'd7;
        if32.in_data  = 32'hC;
        flush32 = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        if32.in_valid = 1'b0;
        if32.out_ready = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("flushA_out_valid", 64'(if32.out_valid), 64'd0);
        end
        check("flushA_done", 64'(done32), 64'(base));
        @(posedge clk);
        #1;
        send32(3'd1, 32'hFF, model(32, 3'd1, 32'hFF));
        drain32();
        check("flushA_next", 64'(done32 - base), 64'd1);

        // Flush on the edge where the oldest result is handed off: that one still counts.
        base = done32;
        send32(3'd7, 32'h11, model(32, 3'd7, 32'h11));
        send32(3'd7, 32'h22, model(32, 3'd7, 32'h22));
        if32.in_valid = 1'b1;
        if32.in_op    = 3'd7;
        if32.in_data  = 32'h33;
        flush32 = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        flush32 = 1'b0;
        if32.in_valid = 1'b0;
        check("flushB_done", 64'(done32 - base), 64'd1);
        check("flushB_out_valid", 64'(if32.out_valid), 64'd0);
        send32(3'd3, 32'h100, model(32, 3'd3, 32'h100));
        drain32();
        check("flushB_next", 64'(done32 - base), 64'd2);

        // Asynchronous reset between edges while the pipe is busy.
        for (int i = 0; i < 3; i++) send32(3'd7, 32'(i + 5), model(32, 3'd7, 32'(i + 5)));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(if32.out_valid), 64'd0);
        check("arst_out_data",  64'(if32.out_data),  64'd0);
        check("arst_out_flag",  64'(if32.out_flag),  64'd0);
        check("arst_out_op",    64'(if32.out_op),    64'd0);
        check("arst_done_cnt",  64'(done32),         64'd0);
        check("arst_in_ready",  64'(if32.in_ready),  64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check("arst_idle", 64'(if32.out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send32(3'd0, 32'hFFFFFFFF, model(32, 3'd0, 32'hFFFFFFFF));
        drain32();
        check("arst_first", 64'(done32), 64'd1);

        // Random traffic with random backpressure and idle gaps.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
                if32.out_ready = ($urandom % 2) != 0;
            end
            op = 3'($urandom_range(0, 7));
            x  = rand_x(32);
            send32(op, x, model(32, op, x));
        end
        rand_rdy = 1'b0;
        drain32();
        check("rand32_done", 64'(done32), 64'd301);

        // WIDTH=8, CNT_W=4: counter wrap then narrow-width corner values.
        check("done8_start", 64'(done8), 64'd0);
        for (int i = 0; i < 17; i++) one8(3'd7, 8'(i), {1'b1, 8'(i)});
        @(posedge clk);
        #1;
        check("wrap8", 64'(done8), 64'd1);
        foreach (tab8[i]) one8(tab8[i].op, tab8[i].x[7:0], {tab8[i].f, tab8[i].r[7:0]});

        // WIDTH=16 random sweep against the reference model.
        for (int i = 0; i < 200; i++) begin
            op = 3'($urandom_range(0, 7));
            x  = rand_x(16);
            m  = model(16, op, x);
            one16(op, x[15:0], {m[32], m[15:0]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
